// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequenced multi-precision CLA adder.
package cla_pkg;

  // Bits handled per slice cycle.
  localparam int unsigned SLICE_W = 4;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; used to size the slice counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_multiword_seq_if.sv
// Operand/result handshake bundle for cla_multiword_seq.
//   master: operand source + result consumer side
//   slave : adder side
interface cla_multiword_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/cla4_slice.sv
// 4-bit carry-look-ahead slice, purely combinational.
//   a, b : slice operands
//   ci   : carry into bit 0
//   s    : slice sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (needed for signed overflow on the top slice)
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic               c1;
  logic               c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened look-ahead carries, no ripple between bit positions.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_multiword_seq.sv
// Sequenced multi-precision adder: WIDTH-bit a+b+cin computed 4 bits per
// cycle through one CLA slice, carry held in a register between slices.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of cla_multiword_seq_if
//                in_valid/in_ready/a/b/cin  - operand handshake
//                out_valid/out_ready        - result handshake
//                sum/cout/ovf               - registered result
//                busy                       - high in RUN or DONE
module cla_multiword_seq
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_multiword_seq_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned CNT_W  = clog2(NSLICE);
  localparam int unsigned SH_W   = WIDTH - SLICE_W;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [SH_W-1:0]    sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               slice_c3;
  logic [WIDTH-1:0]   sum_cat;
  logic               last_slice;

  cla4_slice u_slice (
    .a  (a_sh_q[SLICE_W-1:0]),
    .b  (b_sh_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // New slice result enters at the top; after NSLICE cycles it is the full sum.
  assign sum_cat    = {slice_s, sum_sh_q};
  assign last_slice = (state_q == RUN) && (cnt_q == CNT_W'(NSLICE - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_slice)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; everything holds unless the state says otherwise.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> SLICE_W;
        b_sh_d   = b_sh_q >> SLICE_W;
        sum_sh_d = sum_cat[WIDTH-1:SLICE_W];
        carry_d  = slice_co;
        cnt_d    = last_slice ? '0 : cnt_q + CNT_W'(1);
        if (last_slice) begin
          sum_d  = sum_cat;
          cout_d = slice_co;
          // Signed overflow: carry into MSB differs from carry out of MSB.
          ovf_d  = slice_c3 ^ slice_co;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake flags are direct decodes of the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
module tb_cla_multiword_seq;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic clk;
  logic rst_n;

  cla_multiword_seq_if #(.WIDTH(W)) bus ();

  cla_multiword_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks;
  int     errors;
  int     cyc;
  int     acc_cyc;
  int     n_acc;
  int     n_res;
  logic   prev_ov;
  logic   last_acc;
  logic   last_hs;
  logic [W-1:0] hs_sum;
  logic   hs_cout;
  logic   hs_ovf;
  exp_t   q[$];

  // Reference: plain integer addition; ovf from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
    e.s = full[W-1:0];
    e.c = full[W];
    e.o = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // One clock: compare/monitor at negedge, then advance past the posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    last_hs  = 1'b0;
    if (rst_n) begin
      chk("in_ready_vs_busy", 32'(bus.in_ready), 32'(!bus.busy));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          fail("unexpected_out_valid");
        end else begin
          e = q[0];
          chk("sum", 32'(bus.sum), 32'(e.s));
          chk("cout", 32'(bus.cout), 32'(e.c));
          chk("ovf", 32'(bus.ovf), 32'(e.o));
          if (!prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'd4);
          if (bus.out_ready) begin
            void'(q.pop_front());
            last_hs = 1'b1;
            hs_sum  = bus.sum;
            hs_cout = bus.cout;
            hs_ovf  = bus.ovf;
            n_res++;
          end
        end
      end
      prev_ov = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.cin));
        last_acc = 1'b1;
        acc_cyc  = cyc + 1;
        n_acc++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_acc(input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    if (!last_acc) fail({nm, "_accept_timeout"});
  endtask

  task automatic wait_hs(input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_hs && n < 40);
    if (!last_hs) fail({nm, "_result_timeout"});
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input string nm);
    bus.a = av; bus.b = bv; bus.cin = ci;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    wait_acc(nm);
    bus.in_valid = 1'b0;
    // Operand changes after acceptance must not disturb the result.
    bus.a = ~av; bus.b = ~bv; bus.cin = ~ci;
    wait_hs(nm);
    chk({nm, "_sum"}, 32'(hs_sum), 32'(es));
    chk({nm, "_cout"}, 32'(hs_cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(hs_ovf), 32'(eo));
  endtask

  initial begin
    int n;
    int acc_before;
    checks = 0; errors = 0; cyc = 0; acc_cyc = 0; n_acc = 0; n_res = 0;
    prev_ov = 1'b0; last_acc = 1'b0; last_hs = 1'b0;
    hs_sum = '0; hs_cout = 1'b0; hs_ovf = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;

    #12;
    chk("rst_sum", 32'(bus.sum), 32'h0);
    chk("rst_cout", 32'(bus.cout), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Directed vectors with hand-computed results.
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");

    // Backpressure: result held, second operand set waits for the handshake.
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_acc("bp1");
    bus.a = 16'h0101; bus.b = 16'h0202; bus.cin = 1'b0;
    acc_before = n_acc;
    n = 0;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    if (!bus.out_valid) fail("bp_done_timeout");
    repeat (3) step();
    chk("bp_hold_sum", 32'(bus.sum), 32'h3333);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    chk("bp_no_accept", 32'(n_acc), 32'(acc_before));
    bus.out_ready = 1'b1;
    step();
    chk("bp_handshake", 32'(last_hs), 32'h1);
    chk("bp_no_accept_in_done", 32'(n_acc), 32'(acc_before));
    wait_acc("bp2");
    bus.in_valid = 1'b0;
    wait_hs("bp2");
    chk("bp2_sum", 32'(hs_sum), 32'h0303);

    // Reset during the second RUN cycle aborts the operation.
    bus.a = 16'hABCD; bus.b = 16'h1111; bus.cin = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    wait_acc("rst_abort");
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(bus.sum), 32'h0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    q.delete();
    prev_ov = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
    repeat (8) step();
    run_op(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, "after_abort");

    // Random traffic with random gaps on both sides.
    begin
      int na;
      int res0;
      na = 0;
      res0 = n_res;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      for (int i = 0; i < 40000; i++) begin
        bus.in_valid  = (na < 1000) && ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        step();
        if (last_acc) begin
          na++;
          bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        end
        if (na >= 1000 && q.size() == 0) break;
      end
      bus.in_valid = 1'b0;
      chk("rand_accepts", 32'(na), 32'd1000);
      chk("rand_results", 32'(n_res - res0), 32'd1000);
      chk("rand_queue_empty", 32'(q.size()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
